// File: rtl/xor_crc.sv
// xor_crc: bit-serial Galois-LFSR CRC folding DATA_W-bit words into a CRC_W-bit remainder.
// Latency: DATA_W cycles per accepted word; crc_valid strobes the cycle after the last word's final bit.
// Backpressure: in_ready only in IDLE (1 word per DATA_W+1 cycles), no buffering. XOR_CRC_REFLECT_EN: LSB-first, reflected crc_out.
module xor_crc #(
    parameter int               DATA_W = 8,
    parameter int               CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = 16'h1021,
    parameter logic [CRC_W-1:0] INIT   = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              busy,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_valid
);

    localparam int              CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CRC_W-1:0]  crc, crc_nxt;
    logic [DATA_W-1:0] sh, sh_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              last, last_nxt;
    logic [DATA_W-1:0] cap_dat;
    logic              fb;
    logic              xfer;

    assign in_ready  = (state == IDLE);
    assign busy      = (state == SHIFT) || (state == DONE);
    assign crc_valid = (state == DONE);

    // clear wins over a coincident handshake
    assign xfer = in_valid && in_ready && !clear;
    assign fb   = crc[CRC_W-1] ^ sh[DATA_W-1];

`ifdef XOR_CRC_REFLECT_EN
    always_comb begin
        cap_dat = '0;
        for (int i = 0; i < DATA_W; i++) begin
            cap_dat[i] = in_data[DATA_W-1-i];
        end
    end

    always_comb begin
        crc_out = '0;
        for (int i = 0; i < CRC_W; i++) begin
            crc_out[i] = crc[CRC_W-1-i];
        end
    end
`else
    assign cap_dat = in_data;
    assign crc_out = crc;
`endif

    always_comb begin
        state_nxt = state;
        crc_nxt   = crc;
        sh_nxt    = sh;
        cnt_nxt   = cnt;
        last_nxt  = last;
        if (clear) begin
            state_nxt = IDLE;
            crc_nxt   = INIT;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        sh_nxt    = cap_dat;
                        last_nxt  = in_last;
                        cnt_nxt   = CNT_TOP;
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    crc_nxt = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
                    sh_nxt  = sh << 1;
                    if (cnt == '0) begin
                        state_nxt = last ? DONE : IDLE;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    crc_nxt   = INIT;
                    state_nxt = IDLE;
                end
                default: begin
                    crc_nxt   = INIT;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            crc   <= INIT;
            sh    <= '0;
            cnt   <= '0;
            last  <= 1'b0;
        end else begin
            state <= state_nxt;
            crc   <= crc_nxt;
            sh    <= sh_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
        end
    end

endmodule
